dmem_arbiter: RTL and testbench

- Shares the single DMEM port between the core datapath's load/store path and an external requester (program loader / debug DMA).
- Sits between the datapath's ALU-address/Data_B/rwe_dmem signals and DMEM.
- The core has priority by default. A starvation counter and a bounded lock let the external side make progress.
- Emits core_stall so the core's control logic can freeze pc and suppress register-file writeback.

---
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single DMEM port between the core load/store path and an external
// requester; the core wins by default, bounded by a starvation counter and a burst lock.
module dmem_arbiter #(
   parameter int MAX_WAIT = 4,
   parameter int LOCK_MAX = 8,
   parameter int CNT_W    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  core_rwe,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   output logic [31:0] core_rdata,
   output logic        core_stall,
   input  logic        ext_req,
   input  logic        ext_we,
   input  logic        ext_lock,
   input  logic [31:0] ext_addr,
   input  logic [31:0] ext_wdata,
   output logic        ext_gnt,
   output logic        ext_rvalid,
   output logic [31:0] ext_rdata,
   output logic [1:0]  mem_rwe,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic {
      ST_CORE,
      ST_EXT_LOCK
   } state_t;

   localparam logic [CNT_W-1:0] WAIT_LIM     = CNT_W'(MAX_WAIT);
   localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_MAX - 1);
   localparam bit               LOCK_ALLOWED = (LOCK_MAX > 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic              ext_rvalid_q, ext_rvalid_d;
   logic [31:0]       ext_rdata_q, ext_rdata_d;

   logic              core_active;
   logic              gnt;
   logic              stall;
   logic              ext_owner;
   logic [1:0]        rwe_sel;
   logic [31:0]       addr_sel;
   logic [31:0]       wdata_sel;

   // 11 is an illegal encoding and is treated exactly like no request
   assign core_active = (core_rwe == 2'b01) || (core_rwe == 2'b10);

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      lock_cnt_d = lock_cnt_q;
      gnt        = 1'b0;
      stall      = 1'b0;
      ext_owner  = 1'b0;
      case (state_q)
         ST_CORE: begin
            gnt       = ext_req && (!core_active || (wait_cnt_q == WAIT_LIM));
            ext_owner = gnt;
            stall     = core_active && gnt;
            if (gnt) begin
               wait_cnt_d = '0;
            end else if (ext_req) begin
               if (wait_cnt_q != WAIT_LIM) begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end else begin
               wait_cnt_d = '0;
            end
            if (gnt && ext_lock && LOCK_ALLOWED) begin
               state_d    = ST_EXT_LOCK;
               lock_cnt_d = CNT_W'(1);
            end
         end
         ST_EXT_LOCK: begin
            // ownership is held even on idle cycles, which still count toward the limit
            ext_owner  = 1'b1;
            gnt        = ext_req;
            stall      = core_active;
            wait_cnt_d = '0;
            if (gnt && !ext_lock) begin
               state_d    = ST_CORE;
               lock_cnt_d = '0;
            end else if (lock_cnt_q == LOCK_LAST) begin
               state_d    = ST_CORE;
               lock_cnt_d = '0;
            end else begin
               lock_cnt_d = lock_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d    = ST_CORE;
            wait_cnt_d = '0;
            lock_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      rwe_sel   = 2'b00;
      addr_sel  = core_addr;
      wdata_sel = core_wdata;
      if (ext_owner) begin
         addr_sel  = ext_addr;
         wdata_sel = ext_wdata;
         if (gnt) begin
            rwe_sel = ext_we ? 2'b10 : 2'b01;
         end
      end else if (core_active) begin
         rwe_sel = core_rwe;
      end
   end

   always_comb begin
      ext_rvalid_d = 1'b0;
      ext_rdata_d  = ext_rdata_q;
      if (gnt && !ext_we) begin
         ext_rvalid_d = 1'b1;
         ext_rdata_d  = mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_CORE;
         wait_cnt_q   <= '0;
         lock_cnt_q   <= '0;
         ext_rvalid_q <= 1'b0;
         ext_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         lock_cnt_q   <= lock_cnt_d;
         ext_rvalid_q <= ext_rvalid_d;
         ext_rdata_q  <= ext_rdata_d;
      end
   end

   // combinational outputs are forced quiet while reset is held
   assign ext_gnt    = reset && gnt;
   assign core_stall = reset && stall;
   assign mem_rwe    = reset ? rwe_sel : 2'b00;
   assign mem_addr   = reset ? addr_sel : 32'd0;
   assign mem_wdata  = reset ? wdata_sel : 32'd0;
   assign core_rdata = reset ? mem_rdata : 32'd0;
   assign ext_rvalid = ext_rvalid_q;
   assign ext_rdata  = ext_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter: stimulus pushes expected per-cycle
// responses and read data; a negedge monitor pops and compares them.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  core_rwe;
   logic [31:0] core_addr, core_wdata, core_rdata;
   logic        core_stall;
   logic        ext_req, ext_we, ext_lock;
   logic [31:0] ext_addr, ext_wdata;
   logic        ext_gnt, ext_rvalid;
   logic [31:0] ext_rdata;
   logic [1:0]  mem_rwe;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem [0:255];
   logic        mem_init;

   typedef struct {
      logic        gnt;
      logic        stall;
      logic        rvalid;
      logic        chk_crd;
      logic [1:0]  rwe;
      logic [31:0] addr;
      logic [31:0] crd;
   } exp_t;

   exp_t        cyc_q[$];
   logic [31:0] rd_q[$];
   int          total = 0;
   int          bad = 0;
   int          cyc_id = 0;
   logic        mon_en = 1'b0;
   logic        prev_rd = 1'b0;
   int          w;

   dmem_arbiter #(.MAX_WAIT(4), .LOCK_MAX(8), .CNT_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .core_rwe   (core_rwe),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_rdata (core_rdata),
      .core_stall (core_stall),
      .ext_req    (ext_req),
      .ext_we     (ext_we),
      .ext_lock   (ext_lock),
      .ext_addr   (ext_addr),
      .ext_wdata  (ext_wdata),
      .ext_gnt    (ext_gnt),
      .ext_rvalid (ext_rvalid),
      .ext_rdata  (ext_rdata),
      .mem_rwe    (mem_rwe),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // DMEM: combinational read, write on the rising edge
   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
         mem[4]  <= 32'hDEADBEEF;
         mem[8]  <= 32'h12345678;
         mem[16] <= 32'hA5A50040;
      end else if (mem_rwe == 2'b10) begin
         mem[mem_addr[9:2]] <= mem_wdata;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // xrd is the expected core_rdata when chk_crd, or the expected ext read data on a granted read
   task automatic cyc(input logic [1:0] crwe, input logic [31:0] caddr, input logic [31:0] cwd,
                      input logic ereq, input logic ewe, input logic elock,
                      input logic [31:0] eaddr, input logic [31:0] ewd,
                      input logic xg, input logic xs, input logic [31:0] xrd, input logic chk_crd);
      exp_t e;
      core_rwe   = crwe;
      core_addr  = caddr;
      core_wdata = cwd;
      ext_req    = ereq;
      ext_we     = ewe;
      ext_lock   = elock;
      ext_addr   = eaddr;
      ext_wdata  = ewd;
      e.gnt     = xg;
      e.stall   = xs;
      e.chk_crd = chk_crd;
      e.crd     = xrd;
      e.rwe     = xg ? (ewe ? 2'b10 : 2'b01) : (xs ? 2'b00 : ((crwe == 2'b11) ? 2'b00 : crwe));
      e.addr    = xg ? eaddr : caddr;
      e.rvalid  = prev_rd;
      prev_rd   = xg && !ewe;
      if (prev_rd) rd_q.push_back(xrd);
      cyc_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (ext_rvalid) begin
               if (rd_q.size() == 0) begin
                  chk("rvalid_unexpected", 32'(ext_rvalid), 32'd0);
               end else begin
                  chk("ext_rdata", ext_rdata, rd_q.pop_front());
               end
            end
            if (cyc_q.size() != 0) begin
               e = cyc_q.pop_front();
               cyc_id++;
               $display("cyc %0d gnt=%0b stall=%0b rwe=%b addr=%h rvalid=%0b", cyc_id,
                        ext_gnt, core_stall, mem_rwe, mem_addr, ext_rvalid);
               chk("ext_gnt", 32'(ext_gnt), 32'(e.gnt));
               chk("core_stall", 32'(core_stall), 32'(e.stall));
               chk("mem_rwe", 32'(mem_rwe), 32'(e.rwe));
               chk("ext_rvalid", 32'(ext_rvalid), 32'(e.rvalid));
               if (e.rwe != 2'b00) chk("mem_addr", mem_addr, e.addr);
               if (e.chk_crd) chk("core_rdata", core_rdata, e.crd);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      reset    = 1'b0;
      mem_init = 1'b1;
      core_rwe = 2'b01; core_addr = 32'h10; core_wdata = 32'h0;
      ext_req  = 1'b1; ext_we = 1'b1; ext_lock = 1'b1;
      ext_addr = 32'h20; ext_wdata = 32'h5555AAAA;
      repeat (2) @(posedge clk);
      #1;
      mem_init = 1'b0;
      // outputs quiet during reset even with live requests
      chk("rst_ext_gnt", 32'(ext_gnt), 32'd0);
      chk("rst_core_stall", 32'(core_stall), 32'd0);
      chk("rst_mem_rwe", 32'(mem_rwe), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_core_rdata", core_rdata, 32'd0);
      chk("rst_ext_rvalid", 32'(ext_rvalid), 32'd0);
      chk("rst_ext_rdata", ext_rdata, 32'd0);
      reset  = 1'b1;
      mon_en = 1'b1;

      // core load, ext idle
      cyc(2'b01, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1);
      // ext read, core idle, then the rvalid pulse and its drop
      cyc(2'b00, 0, 0, 1, 0, 0, 32'h20, 0, 1, 0, 32'h12345678, 0);
      cyc(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // core stores every cycle, ext held: granted on the fifth cycle
      for (int i = 0; i < 5; i++) begin
         cyc(2'b10, 32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 1, 0, 0, 32'h40, 0,
             (i == 4), (i == 4), 32'hA5A50040, 0);
      end
      cyc(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         chk("store_landed", mem[64 + i], 32'hC0DE0000 + 32'(i));
      end
      chk("stalled_store_dropped", mem[68], 32'd0);

      // 12-word locked write burst against a loading core
      w = 0;
      for (int k = 1; k <= 21; k++) begin
         logic g;
         g = ((k >= 5) && (k <= 12)) || ((k >= 17) && (k <= 20));
         cyc(2'b01, 32'h10, 0, (w < 12), 1, (w < 11), 32'h200 + 32'(4 * w),
             32'hB0000000 + 32'(w), g, g, 32'hDEADBEEF, !g);
         if (g) w++;
      end
      for (int i = 0; i < 12; i++) begin
         chk("burst_word", mem[128 + i], 32'hB0000000 + 32'(i));
      end

      // reset during a locked burst right after a granted read
      cyc(2'b00, 0, 0, 1, 0, 1, 32'h20, 0, 1, 0, 32'h12345678, 0);
      reset  = 1'b0;
      mon_en = 1'b0;
      rd_q.delete();
      prev_rd  = 1'b0;
      core_rwe = 2'b01; core_addr = 32'h10;
      #1;
      chk("midrst_ext_rvalid", 32'(ext_rvalid), 32'd0);
      chk("midrst_ext_gnt", 32'(ext_gnt), 32'd0);
      chk("midrst_core_stall", 32'(core_stall), 32'd0);
      chk("midrst_mem_rwe", 32'(mem_rwe), 32'd0);
      @(posedge clk);
      #1;
      reset  = 1'b1;
      mon_en = 1'b1;
      // back in CORE with a cleared wait count: four refusals, grant on the fifth
      for (int i = 0; i < 5; i++) begin
         cyc(2'b01, 32'h10, 0, 1, 0, 0, 32'h20, 0, (i == 4), (i == 4), 32'h12345678, 0);
      end
      cyc(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // illegal core encoding is never forwarded
      cyc(2'b11, 32'h80, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rwe11_no_write", mem[32], 32'd0);

      repeat (2) @(posedge clk);
      #1;
      chk("cyc_q_drained", 32'(cyc_q.size()), 32'd0);
      chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
